// File: rtl/atm_pin_controller.sv
// Card/PIN controller: edge-detected keypad entry, inactivity timeout, cash on match,
// card destruction after MAX_TRIES consecutive failures, return to idle after each session.
module atm_pin_controller #(
    parameter int DIGIT_W   = 3,
    parameter int CODE_LEN  = 3,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 30,
    parameter logic [CODE_LEN*DIGIT_W-1:0] PIN = 9'b001_011_111
) (
    input  logic                               clk_2,
    input  logic                               reset,
    input  logic                               card,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_code,
    output logic                               cash,
    output logic                               destroy,
    output logic                               wrong,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic [$clog2(CODE_LEN+1)-1:0]      digits
);

    localparam int CW  = CODE_LEN * DIGIT_W;
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int DGW = $clog2(CODE_LEN + 1);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ENTRY       = 3'd1;
    localparam logic [2:0] S_CHECK       = 3'd2;
    localparam logic [2:0] S_DISPENSE    = 3'd3;
    localparam logic [2:0] S_DESTROY     = 3'd4;
    localparam logic [2:0] S_WAIT_REMOVE = 3'd5;

    localparam logic [TRW-1:0] MAXT     = TRW'(MAX_TRIES);
    localparam logic [DGW-1:0] DIG_LAST = DGW'(CODE_LEN - 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit             TO_EN    = (TIMEOUT > 0);

    logic           key_q;
    logic           press;
    logic [CW-1:0]  code_buf;
    logic [CW-1:0]  code_shifted;
    logic [TRW-1:0] fails;
    logic [TRW-1:0] fails_inc;
    logic [TW-1:0]  idle_cnt;
    logic           fail_force;
    logic           timed_out;
    logic           match;

    assign press        = key_valid & ~key_q;
    assign code_shifted = (code_buf << DIGIT_W) | CW'(key_code);
    assign timed_out    = TO_EN && (idle_cnt == TO_LAST);
    assign match        = (code_buf == PIN) && !fail_force;
    assign fails_inc    = (fails == MAXT) ? fails : fails + 1'b1;

    assign tries_left = MAXT - fails;
    assign cash       = (state == S_DISPENSE);
    assign destroy    = (state == S_DESTROY);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state      <= S_IDLE;
            key_q      <= 1'b0;
            code_buf   <= '0;
            digits     <= '0;
            fails      <= '0;
            idle_cnt   <= '0;
            fail_force <= 1'b0;
            wrong      <= 1'b0;
        end else begin
            key_q <= key_valid;
            wrong <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (card) begin
                        state      <= S_ENTRY;
                        code_buf   <= '0;
                        digits     <= '0;
                        idle_cnt   <= '0;
                        fail_force <= 1'b0;
                    end
                end
                S_ENTRY: begin
                    // A completing keypress wins over card removal in the same cycle.
                    if (press && digits == DIG_LAST) begin
                        code_buf <= code_shifted;
                        digits   <= digits + 1'b1;
                        state    <= S_CHECK;
                    end else if (!card) begin
                        state <= S_IDLE;
                    end else if (press) begin
                        code_buf <= code_shifted;
                        digits   <= digits + 1'b1;
                        idle_cnt <= '0;
                    end else if (timed_out) begin
                        fail_force <= 1'b1;
                        state      <= S_CHECK;
                    end else if (idle_cnt != TO_LAST) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        fails <= '0;
                        state <= S_DISPENSE;
                    end else begin
                        fails <= fails_inc;
                        if (fails_inc == MAXT) begin
                            state <= S_DESTROY;
                        end else begin
                            wrong      <= 1'b1;
                            digits     <= '0;
                            code_buf   <= '0;
                            idle_cnt   <= '0;
                            fail_force <= 1'b0;
                            state      <= card ? S_ENTRY : S_IDLE;
                        end
                    end
                end
                S_DISPENSE: state <= S_WAIT_REMOVE;
                S_DESTROY: begin
                    fails <= '0;
                    state <= S_WAIT_REMOVE;
                end
                S_WAIT_REMOVE: begin
                    if (!card) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_pin_controller.sv
// Scoreboard bench for atm_pin_controller: directed sessions push expected pulses,
// a negedge monitor pops and compares them whenever cash/wrong/destroy fires.
module tb_atm_pin_controller;

    logic       clk_2;
    logic       reset;
    logic       card;
    logic       key_valid;
    logic [2:0] key_code;
    logic       cash;
    logic       destroy;
    logic       wrong;
    logic [2:0] state;
    logic [1:0] tries_left;
    logic [1:0] digits;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] kind;   // {cash, wrong, destroy}
        logic [1:0] tries;
    } ev_t;
    ev_t exp_q[$];

    localparam logic [2:0] K_CASH    = 3'b100;
    localparam logic [2:0] K_WRONG   = 3'b010;
    localparam logic [2:0] K_DESTROY = 3'b001;

    atm_pin_controller dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .card       (card),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .cash       (cash),
        .destroy    (destroy),
        .wrong      (wrong),
        .state      (state),
        .tries_left (tries_left),
        .digits     (digits)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic push(input logic [2:0] kind, input logic [1:0] tries);
        ev_t e;
        e.kind  = kind;
        e.tries = tries;
        exp_q.push_back(e);
    endtask

    // One keypress: rising edge sampled at the first tick, released at the second.
    task automatic press(input logic [2:0] d);
        key_code  = d;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic enter3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        press(a);
        tick();
        press(b);
        tick();
        press(c);
    endtask

    always @(negedge clk_2) begin
        if (cash || wrong || destroy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, cash, wrong, destroy}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {29'd0, cash, wrong, destroy}, {29'd0, e.kind});
                check("pulse_tries", {30'd0, tries_left}, {30'd0, e.tries});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        card      = 1'b0;
        key_valid = 1'b0;
        key_code  = 3'd0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_tries", tries_left, 3);
        check("rst_digits", digits, 0);
        check("rst_pulses", {cash, wrong, destroy}, 0);
        reset = 1'b0;
        tick();
        check("idle_state", state, 0);

        // Correct PIN
        card = 1'b1;
        tick();
        check("card_in_entry", state, 1);
        push(K_CASH, 2'd3);
        press(3'd1);
        check("digit_count1", digits, 1);
        tick();
        press(3'd3);
        tick();
        press(3'd7);
        check("ok_dispense", state, 3);
        tick();
        check("ok_wait_remove", state, 5);
        check("ok_tries", tries_left, 3);
        card = 1'b0;
        tick();
        check("ok_back_idle", state, 0);

        // Held key counts once; key held before insertion does not count
        card = 1'b1;
        tick();
        key_code  = 3'd1;
        key_valid = 1'b1;
        repeat (10) tick();
        check("held_digits", digits, 1);
        key_valid = 1'b0;
        tick();
        card = 1'b0;
        tick();
        check("held_abort_idle", state, 0);
        key_code  = 3'd2;
        key_valid = 1'b1;
        tick();
        tick();
        card = 1'b1;
        tick();
        tick();
        tick();
        check("preheld_digits", digits, 0);
        key_valid = 1'b0;
        card      = 1'b0;
        tick();

        // Three failures destroy the card
        card = 1'b1;
        tick();
        push(K_WRONG, 2'd2);
        enter3(3'd1, 3'd3, 3'd6);
        check("fail1_state", state, 1);
        check("fail1_tries", tries_left, 2);
        check("fail1_digits", digits, 0);
        tick();
        push(K_WRONG, 2'd1);
        enter3(3'd1, 3'd3, 3'd6);
        check("fail2_tries", tries_left, 1);
        tick();
        push(K_DESTROY, 2'd0);
        enter3(3'd1, 3'd3, 3'd6);
        check("fail3_destroy", state, 4);
        tick();
        check("fail3_wait", state, 5);
        check("fail3_tries", tries_left, 3);
        card = 1'b0;
        tick();

        // Failure count survives card removal
        card = 1'b1;
        tick();
        push(K_WRONG, 2'd2);
        enter3(3'd1, 3'd3, 3'd6);
        card = 1'b0;
        tick();
        check("persist_idle", state, 0);
        check("persist_tries", tries_left, 2);
        card = 1'b1;
        tick();
        push(K_CASH, 2'd3);
        enter3(3'd1, 3'd3, 3'd7);
        check("persist_dispense", state, 3);
        tick();
        check("persist_tries_clr", tries_left, 3);
        card = 1'b0;
        tick();

        // Inactivity timeout after one digit
        card = 1'b1;
        tick();
        push(K_WRONG, 2'd2);
        press(3'd1);
        repeat (28) tick();
        check("to_not_early", state, 1);
        check("to_digits_kept", digits, 1);
        tick();
        check("to_check", state, 2);
        tick();
        check("to_entry", state, 1);
        check("to_digits", digits, 0);
        check("to_tries", tries_left, 2);
        card = 1'b0;
        tick();

        // Abort after two digits
        card = 1'b1;
        tick();
        press(3'd1);
        tick();
        press(3'd3);
        check("abort_digits", digits, 2);
        card = 1'b0;
        tick();
        check("abort_idle", state, 0);
        check("abort_tries", tries_left, 2);

        // Reset during DISPENSE
        card = 1'b1;
        tick();
        push(K_CASH, 2'd3);
        enter3(3'd1, 3'd3, 3'd7);
        check("rst_in_dispense", state, 3);
        reset = 1'b1;
        tick();
        check("rst_cash", cash, 0);
        check("rst_state2", state, 0);
        check("rst_tries2", tries_left, 3);
        reset = 1'b0;
        card  = 1'b0;
        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
